// File: rtl/spart_fifo_if.sv
// spart_fifo_if: processor-side SPART register block with TX/RX FIFOs, CTRL/STATUS, sticky errors, TX drain FSM.
// Latency: reads are combinational in the access cycle; writes and FIFO side effects land at the next clk edge.
// Backpressure: a push to a full TX FIFO is dropped (tx_overflow); an rx_valid into a full RX FIFO is dropped (rx_overrun).
module spart_fifo_if #(
   parameter int DATA_W   = 8,
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iocs,
   input  logic                iorw,
   input  logic [1:0]          ioaddr,
   inout  wire  [DATA_W-1:0]   databus,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic                rx_valid,
   output logic [DATA_W-1:0]   tx_data,
   output logic                tx_start,
   input  logic                tx_ready,
   output logic [2*DATA_W-1:0] divisor,
   output logic                rda,
   output logic                irq
);

   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_PW + 1;
   localparam int RX_PW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_PW + 1;

   localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
   localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

   localparam logic [1:0] ADDR_DATA = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DLO  = 2'b10;
   localparam logic [1:0] ADDR_DHI  = 2'b11;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_WAIT_ACK  = 2'd1,
      TX_WAIT_DONE = 2'd2
   } tx_state_t;

   // ---------------------------------------------------------------- state
   tx_state_t          tx_state_q, tx_state_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;

   logic [DATA_W-1:0]  tx_mem_q [TX_DEPTH];
   logic [DATA_W-1:0]  tx_mem_d [TX_DEPTH];
   logic [TX_PW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d;
   logic [TX_PW-1:0]   tx_rd_ptr_q, tx_rd_ptr_d;
   logic [TX_CW-1:0]   tx_count_q, tx_count_d;

   logic [DATA_W-1:0]  rx_mem_q [RX_DEPTH];
   logic [DATA_W-1:0]  rx_mem_d [RX_DEPTH];
   logic [RX_PW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d;
   logic [RX_PW-1:0]   rx_rd_ptr_q, rx_rd_ptr_d;
   logic [RX_CW-1:0]   rx_count_q, rx_count_d;

   logic [DATA_W-1:0]  div_low_q, div_low_d;
   logic [DATA_W-1:0]  div_high_q, div_high_d;
   logic               rx_irq_en_q, rx_irq_en_d;
   logic               tx_irq_en_q, tx_irq_en_d;
   logic               rx_overrun_q, rx_overrun_d;
   logic               tx_overflow_q, tx_overflow_d;

   // ---------------------------------------------------------------- decode
   logic               wr_acc, rd_acc;
   logic               cpu_tx_wr, ctrl_wr, flush, rx_rd, stat_rd;
   logic               tx_full, tx_empty, tbr, rx_full;
   logic               tx_launch, tx_push, rx_pop, rx_push;
   logic               tx_overflow_set, rx_overrun_set;
   logic [DATA_W-1:0]  status;
   logic [DATA_W-1:0]  rd_data;

   assign wr_acc    = iocs & ~iorw;
   assign rd_acc    = iocs & iorw;
   assign cpu_tx_wr = wr_acc && (ioaddr == ADDR_DATA);
   assign ctrl_wr   = wr_acc && (ioaddr == ADDR_STAT);
   assign flush     = ctrl_wr && databus[2];
   assign rx_rd     = rd_acc && (ioaddr == ADDR_DATA);
   assign stat_rd   = rd_acc && (ioaddr == ADDR_STAT);

   assign tx_full   = (tx_count_q == TX_FULL_CNT);
   assign tbr       = ~tx_full;
   assign tx_empty  = (tx_count_q == '0) && (tx_state_q == TX_IDLE);
   assign rx_full   = (rx_count_q == RX_FULL_CNT);

   assign rda       = (rx_count_q != '0);
   assign irq       = (rx_irq_en_q & rda) | (tx_irq_en_q & tx_empty) | rx_overrun_q | tx_overflow_q;

   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign divisor   = {div_high_q, div_low_q};

   // The bus is only driven during a CPU read; everyone else sees high-Z.
   assign databus   = rd_acc ? rd_data : 'z;

   // TX drain FSM: hand one character to the engine, then wait for its busy/idle handshake.
   // A flush in the same cycle suppresses the launch so a flushed character is never sent.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_launch  = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      unique case (tx_state_q)
         TX_IDLE: begin
            if ((tx_count_q != '0) && tx_ready && !flush) begin
               tx_launch  = 1'b1;
               tx_start_d = 1'b1;
               tx_data_d  = tx_mem_q[tx_rd_ptr_q];
               tx_state_d = TX_WAIT_ACK;
            end
         end
         TX_WAIT_ACK: begin
            if (!tx_ready) tx_state_d = TX_WAIT_DONE;
         end
         TX_WAIT_DONE: begin
            if (tx_ready) tx_state_d = TX_IDLE;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // TX FIFO: CPU push vs FSM pop; a push onto a full FIFO still succeeds if the FSM pops that cycle.
   always_comb begin
      tx_mem_d        = tx_mem_q;
      tx_wr_ptr_d     = tx_wr_ptr_q;
      tx_rd_ptr_d     = tx_rd_ptr_q;
      tx_count_d      = tx_count_q;
      tx_push         = cpu_tx_wr && (!tx_full || tx_launch);
      tx_overflow_set = cpu_tx_wr && tx_full && !tx_launch;
      if (tx_push) begin
         tx_mem_d[tx_wr_ptr_q] = databus;
         tx_wr_ptr_d           = tx_wr_ptr_q + TX_PW'(1);
      end
      if (tx_launch) tx_rd_ptr_d = tx_rd_ptr_q + TX_PW'(1);
      if (tx_push && !tx_launch)      tx_count_d = tx_count_q + TX_CW'(1);
      else if (tx_launch && !tx_push) tx_count_d = tx_count_q - TX_CW'(1);
      if (flush) begin
         tx_wr_ptr_d = '0;
         tx_rd_ptr_d = '0;
         tx_count_d  = '0;
      end
   end

   // RX FIFO: engine push vs CPU pop; flush overrides both and swallows a same-cycle rx_valid.
   always_comb begin
      rx_mem_d       = rx_mem_q;
      rx_wr_ptr_d    = rx_wr_ptr_q;
      rx_rd_ptr_d    = rx_rd_ptr_q;
      rx_count_d     = rx_count_q;
      rx_pop         = rx_rd && rda && !flush;
      rx_push        = rx_valid && (!rx_full || rx_pop) && !flush;
      rx_overrun_set = rx_valid && rx_full && !rx_pop && !flush;
      if (rx_push) begin
         rx_mem_d[rx_wr_ptr_q] = rx_data;
         rx_wr_ptr_d           = rx_wr_ptr_q + RX_PW'(1);
      end
      if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + RX_PW'(1);
      if (rx_push && !rx_pop)      rx_count_d = rx_count_q + RX_CW'(1);
      else if (rx_pop && !rx_push) rx_count_d = rx_count_q - RX_CW'(1);
      if (flush) begin
         rx_wr_ptr_d = '0;
         rx_rd_ptr_d = '0;
         rx_count_d  = '0;
      end
   end

   // Divisor, CTRL enables and sticky flags; a flag set beats a same-cycle clear.
   always_comb begin
      div_low_d     = div_low_q;
      div_high_d    = div_high_q;
      rx_irq_en_d   = rx_irq_en_q;
      tx_irq_en_d   = tx_irq_en_q;
      rx_overrun_d  = rx_overrun_q;
      tx_overflow_d = tx_overflow_q;
      if (wr_acc && (ioaddr == ADDR_DLO)) div_low_d  = databus;
      if (wr_acc && (ioaddr == ADDR_DHI)) div_high_d = databus;
      if (ctrl_wr) begin
         rx_irq_en_d = databus[0];
         tx_irq_en_d = databus[1];
      end
      if (stat_rd || flush) begin
         rx_overrun_d  = 1'b0;
         tx_overflow_d = 1'b0;
      end
      if (rx_overrun_set)  rx_overrun_d  = 1'b1;
      if (tx_overflow_set) tx_overflow_d = 1'b1;
   end

   // Read mux: STATUS is zero-extended; an empty RX FIFO reads as 0.
   always_comb begin
      status    = '0;
      status[0] = rda;
      status[1] = tbr;
      status[2] = tx_empty;
      status[3] = rx_full;
      status[4] = rx_overrun_q;
      status[5] = tx_overflow_q;
      rd_data   = '0;
      unique case (ioaddr)
         ADDR_DATA: rd_data = rda ? rx_mem_q[rx_rd_ptr_q] : '0;
         ADDR_STAT: rd_data = status;
         ADDR_DLO:  rd_data = div_low_q;
         ADDR_DHI:  rd_data = div_high_q;
         default:   rd_data = '0;
      endcase
   end

   // All state registers, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q    <= TX_IDLE;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         tx_mem_q      <= '{default: '0};
         tx_wr_ptr_q   <= '0;
         tx_rd_ptr_q   <= '0;
         tx_count_q    <= '0;
         rx_mem_q      <= '{default: '0};
         rx_wr_ptr_q   <= '0;
         rx_rd_ptr_q   <= '0;
         rx_count_q    <= '0;
         div_low_q     <= '0;
         div_high_q    <= '0;
         rx_irq_en_q   <= 1'b0;
         tx_irq_en_q   <= 1'b0;
         rx_overrun_q  <= 1'b0;
         tx_overflow_q <= 1'b0;
      end else begin
         tx_state_q    <= tx_state_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         tx_mem_q      <= tx_mem_d;
         tx_wr_ptr_q   <= tx_wr_ptr_d;
         tx_rd_ptr_q   <= tx_rd_ptr_d;
         tx_count_q    <= tx_count_d;
         rx_mem_q      <= rx_mem_d;
         rx_wr_ptr_q   <= rx_wr_ptr_d;
         rx_rd_ptr_q   <= rx_rd_ptr_d;
         rx_count_q    <= rx_count_d;
         div_low_q     <= div_low_d;
         div_high_q    <= div_high_d;
         rx_irq_en_q   <= rx_irq_en_d;
         tx_irq_en_q   <= tx_irq_en_d;
         rx_overrun_q  <= rx_overrun_d;
         tx_overflow_q <= tx_overflow_d;
      end
   end

endmodule

// File: tb/tb_spart_fifo_if.sv
// tb_spart_fifo_if: exercises spart_fifo_if through its CPU bus, an rx pulse source and a tx engine model.
// Reference is a pair of byte queues plus a sticky-flag bit, updated per bus operation.
// The tx engine model drops tx_ready one cycle after tx_start and raises it ten cycles later.
module tb_spart_fifo_if;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          iocs = 1'b0;
   logic          iorw = 1'b0;
   logic [1:0]    ioaddr = 2'b00;
   wire  [DW-1:0] databus;
   logic [DW-1:0] db_drv = '0;
   logic          db_oe = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic [DW-1:0] tx_data;
   logic          tx_start;
   logic          tx_ready = 1'b1;
   logic [2*DW-1:0] divisor;
   logic          rda;
   logic          irq;

   int   vectors = 0;
   int   miscompares = 0;
   bit   eng_hold = 1'b0;
   int   pulses = 0;
   logic [7:0] got[$];
   logic [7:0] rx_q[$];
   bit   ovr_m = 1'b0;

   assign databus = db_oe ? db_drv : 'z;

   spart_fifo_if #(.DATA_W(DW), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_start(tx_start),
      .tx_ready(tx_ready), .divisor(divisor), .rda(rda), .irq(irq)
   );

   always #5 clk = ~clk;

   // count every cycle in which tx_start is high
   always @(negedge clk) if (tx_start) pulses++;

   // tx engine model
   initial forever begin
      @(negedge clk);
      if (tx_start) begin
         got.push_back(tx_data);
         @(posedge clk); #1 tx_ready = 1'b0;
         repeat (10) @(posedge clk);
         #1 tx_ready = 1'b1;
      end else begin
         tx_ready = !eng_hold;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // expected STATUS while the TX side is idle and empty
   function automatic logic [7:0] rx_stat();
      return {3'b000, ovr_m, (rx_q.size() == 8), 1'b1, 1'b1, (rx_q.size() != 0)};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; db_drv = d; db_oe = 1'b1;
      @(posedge clk); #1;
      iocs = 1'b0; db_oe = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #2 d = databus;
      @(posedge clk); #1;
      iocs = 1'b0; iorw = 1'b0;
   endtask

   task automatic rx_in(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (rx_q.size() == 8) ovr_m = 1'b1;
      else rx_q.push_back(d);
   endtask

   task automatic test_reset();
      logic [7:0] v;
      #12;
      vectors++; if ({tx_start, tx_data, divisor, rda, irq} !== '0) begin miscompares++;
         $display("FAIL reset_outputs: got %h want 0", {tx_start, tx_data, divisor, rda, irq}); end
      @(posedge clk); #1 rst = 1'b1;
      idle(1);
      bus_read(2'b01, v);
      vectors++; if (v !== 8'h06) begin miscompares++; $display("FAIL reset_status: got %h want 06", v); end
      vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL reset_no_start: got %0d want 0", pulses); end
   endtask

   task automatic test_divisor();
      logic [7:0] v;
      bus_write(2'b10, 8'h45);
      vectors++; if (divisor !== 16'h0045) begin miscompares++; $display("FAIL div_low: got %h want 0045", divisor); end
      bus_write(2'b11, 8'h01);
      vectors++; if (divisor !== 16'h0145) begin miscompares++; $display("FAIL div_full: got %h want 0145", divisor); end
      bus_read(2'b10, v);
      vectors++; if (v !== 8'h45) begin miscompares++; $display("FAIL rd_div_low: got %h want 45", v); end
      bus_read(2'b11, v);
      vectors++; if (v !== 8'h01) begin miscompares++; $display("FAIL rd_div_high: got %h want 01", v); end
      iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b01; db_drv = 8'h5A; db_oe = 1'b1;
      #2;
      vectors++; if (databus !== 8'h5A) begin miscompares++; $display("FAIL bus_release: got %h want 5a", databus); end
      db_oe = 1'b0; iorw = 1'b0;
      idle(1);
   endtask

   task automatic test_tx_overflow();
      logic [7:0] v;
      int p0;
      eng_hold = 1'b1;
      idle(2);
      for (int i = 0; i < 8; i++) bus_write(2'b00, 8'(8'h11 + i));
      bus_read(2'b01, v);
      vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL tx_full_status: got %h want 00", v); end
      bus_write(2'b00, 8'h99);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL ovf_irq: got %b want 1", irq); end
      bus_read(2'b01, v);
      vectors++; if (v !== 8'h20) begin miscompares++; $display("FAIL ovf_status: got %h want 20", v); end
      bus_read(2'b01, v);
      vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL ovf_cleared: got %h want 00", v); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL ovf_irq_clr: got %b want 0", irq); end
      p0 = pulses;
      got.delete();
      eng_hold = 1'b0;
      for (int c = 0; c < 400 && pulses < p0 + 8; c++) idle(1);
      idle(20);
      vectors++; if (pulses - p0 !== 8) begin miscompares++; $display("FAIL tx_pulses: got %0d want 8", pulses - p0); end
      vectors++; if (got.size() !== 8) begin miscompares++; $display("FAIL tx_count: got %0d want 8", got.size()); end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         vectors++; if (got[i] !== 8'(8'h11 + i)) begin miscompares++;
            $display("FAIL tx_order[%0d]: got %h want %h", i, got[i], 8'(8'h11 + i)); end
      end
      bus_read(2'b01, v);
      vectors++; if (v !== 8'h06) begin miscompares++; $display("FAIL tx_empty: got %h want 06", v); end
   endtask

   task automatic test_rx_fill();
      logic [7:0] v, e;
      for (int i = 0; i < 8; i++) rx_in(8'(8'hA0 + i));
      vectors++; if (rda !== 1'b1) begin miscompares++; $display("FAIL rx_rda: got %b want 1", rda); end
      bus_read(2'b01, v);
      vectors++; if (v !== rx_stat()) begin miscompares++; $display("FAIL rx_full: got %h want %h", v, rx_stat()); end
      rx_in(8'hFF);
      bus_read(2'b01, v);
      vectors++; if (v !== rx_stat()) begin miscompares++; $display("FAIL rx_overrun: got %h want %h", v, rx_stat()); end
      ovr_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus_read(2'b00, v);
         e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
         vectors++; if (v !== e) begin miscompares++; $display("FAIL rx_read[%0d]: got %h want %h", i, v, e); end
      end
      vectors++; if (rda !== 1'b0) begin miscompares++; $display("FAIL rx_drained: got %b want 0", rda); end
      bus_read(2'b00, v);
      vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL rx_empty_read: got %h want 00", v); end
      bus_read(2'b01, v);
      vectors++; if (v !== rx_stat()) begin miscompares++; $display("FAIL rx_empty_status: got %h want %h", v, rx_stat()); end
   endtask

   task automatic test_rx_simul();
      logic [7:0] v, e;
      for (int i = 0; i < 8; i++) rx_in(8'($urandom));
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; rx_valid = 1'b1; rx_data = 8'hB5;
      #2 v = databus;
      @(posedge clk); #1;
      iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
      e = rx_q.pop_front();
      rx_q.push_back(8'hB5);
      vectors++; if (v !== e) begin miscompares++; $display("FAIL simul_read: got %h want %h", v, e); end
      bus_read(2'b01, v);
      vectors++; if (v !== rx_stat()) begin miscompares++; $display("FAIL simul_status: got %h want %h", v, rx_stat()); end
      for (int i = 0; i < 8; i++) begin
         bus_read(2'b00, v);
         e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
         vectors++; if (v !== e) begin miscompares++; $display("FAIL simul_drain[%0d]: got %h want %h", i, v, e); end
      end
      vectors++; if (v !== 8'hB5) begin miscompares++; $display("FAIL simul_last: got %h want b5", v); end
   endtask

   task automatic test_irq_flush();
      logic [7:0] v;
      int p0;
      bus_write(2'b01, 8'h01);
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_rx_empty: got %b want 0", irq); end
      rx_in(8'h3C);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rx: got %b want 1", irq); end
      eng_hold = 1'b1;
      idle(2);
      bus_write(2'b00, 8'h21);
      bus_write(2'b00, 8'h22);
      rx_in(8'h3D);
      bus_write(2'b01, 8'h04);
      rx_q.delete();
      bus_read(2'b01, v);
      vectors++; if (v !== 8'h06) begin miscompares++; $display("FAIL flush_status: got %h want 06", v); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL flush_irq: got %b want 0", irq); end
      rx_in(8'h3E);
      vectors++; if ({rda, irq} !== 2'b10) begin miscompares++; $display("FAIL flush_en_cleared: got %b want 10", {rda, irq}); end
      bus_write(2'b01, 8'h02);
      vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
      bus_write(2'b01, 8'h04);
      rx_q.delete();
      p0 = pulses;
      eng_hold = 1'b0;
      idle(30);
      vectors++; if (pulses !== p0) begin miscompares++; $display("FAIL flush_no_tx: got %0d want %0d", pulses, p0); end
   endtask

   task automatic test_random();
      logic [7:0] v, e, d;
      logic [7:0] texp[$];
      int npush = 0;
      got.delete();
      for (int n = 0; n < 160; n++) begin
         case ($urandom_range(0, 3))
            0: rx_in(8'($urandom));
            1: begin
               bus_read(2'b00, v);
               e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
               vectors++; if (v !== e) begin miscompares++; $display("FAIL rand_rx[%0d]: got %h want %h", n, v, e); end
            end
            2: begin
               bus_read(2'b01, v);
               vectors++; if ((v & 8'h19) !== (rx_stat() & 8'h19)) begin miscompares++;
                  $display("FAIL rand_status[%0d]: got %h want %h", n, v & 8'h19, rx_stat() & 8'h19); end
               ovr_m = 1'b0;
            end
            default: begin
               if (npush < 6) begin
                  d = 8'($urandom);
                  bus_write(2'b00, d);
                  texp.push_back(d);
                  npush++;
               end else idle(1);
            end
         endcase
      end
      for (int c = 0; c < 500 && got.size() < texp.size(); c++) idle(1);
      vectors++; if (got.size() !== texp.size()) begin miscompares++;
         $display("FAIL rand_tx_count: got %0d want %0d", got.size(), texp.size()); end
      for (int i = 0; i < texp.size() && i < got.size(); i++) begin
         vectors++; if (got[i] !== texp[i]) begin miscompares++;
            $display("FAIL rand_tx[%0d]: got %h want %h", i, got[i], texp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      int p0, p1;
      bus_write(2'b01, 8'h05);
      rx_q.delete(); ovr_m = 1'b0;
      idle(15);
      bus_write(2'b10, 8'h33);
      rx_in(8'h44);
      for (int i = 0; i < 3; i++) bus_write(2'b00, 8'(8'h61 + i));
      p0 = pulses;
      for (int c = 0; c < 50 && pulses == p0; c++) idle(1);
      idle(4);
      vectors++; if ({rda, irq} !== 2'b11) begin miscompares++; $display("FAIL pre_reset: got %b want 11", {rda, irq}); end
      #3 rst = 1'b0;
      #1;
      vectors++; if ({tx_start, tx_data, divisor, rda, irq} !== '0) begin miscompares++;
         $display("FAIL midreset_outputs: got %h want 0", {tx_start, tx_data, divisor, rda, irq}); end
      idle(2);
      rst = 1'b1;
      rx_q.delete();
      p1 = pulses;
      idle(40);
      vectors++; if (pulses !== p1) begin miscompares++; $display("FAIL midreset_no_tx: got %0d want %0d", pulses, p1); end
      bus_read(2'b01, v);
      vectors++; if (v !== 8'h06) begin miscompares++; $display("FAIL midreset_status: got %h want 06", v); end
      bus_write(2'b00, 8'h77);
      for (int c = 0; c < 50 && pulses == p1; c++) idle(1);
      idle(1);
      vectors++; if (pulses - p1 !== 1) begin miscompares++; $display("FAIL post_reset_tx: got %0d want 1", pulses - p1); end
      vectors++; if (got.size() == 0 || got[got.size()-1] !== 8'h77) begin miscompares++;
         $display("FAIL post_reset_data: got %h want 77", (got.size() == 0) ? 8'h00 : got[got.size()-1]); end
   endtask

   initial begin
      test_reset();
      test_divisor();
      test_tx_overflow();
      test_rx_fill();
      test_rx_simul();
      test_irq_flush();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spart_fifo_if.md
Name: spart_fifo_if

Overview:
Parametrised bus-side register interface for the SPART, the successor to the single-buffer interface. Sits between the processor-side databus and the spart_rx/spart_tx character engines. Adds TX and RX FIFOs of configurable depth, a control register with interrupt enables and flush, sticky error flags, and an internal TX drain state machine that feeds the transmitter one character at a time.

Parameters:
DATA_W, 8, width of the databus and of one character; must be >= 8.
TX_DEPTH, 8, TX FIFO entries; a power of 2, >= 2.
RX_DEPTH, 8, RX FIFO entries; a power of 2, >= 2.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
iocs  input  1  I/O chip select; an access occurs only when high
iorw  input  1  1 = read, 0 = write
ioaddr  input  2  register select
databus  inout  DATA_W  processor data bus
rx_data  input  DATA_W  received character from the rx engine, start/stop already stripped
rx_valid  input  1  one-cycle pulse; rx_data is valid
tx_data  output  DATA_W  character handed to the tx engine
tx_start  output  1  one-cycle pulse; tx engine latches tx_data
tx_ready  input  1  tx engine idle; drops after tx_start, rises when the character is done
divisor  output  2*DATA_W  baud divisor {div_high, div_low} to the rx/tx engines
rda  output  1  RX FIFO not empty
irq  output  1  interrupt request, level

Behaviour:
- Reset (async, rst=0): both FIFOs are empty with all pointers and counts 0. div_low, div_high, ctrl, tx_data, tx_start and the sticky flags are 0. TX FSM is in IDLE. rda=0, irq=0.
- databus is driven only when iocs && iorw; otherwise it is high-Z.
- Register map, reads (combinational data, side effects at the clock edge):
  - 00: RX FIFO head, popped at the edge. When RX is empty the read returns 0 and does not pop.
  - 01: STATUS, zero-extended. Bit0 rda; bit1 tbr (TX FIFO not full); bit2 tx_empty (TX FIFO empty and FSM IDLE); bit3 rx_full; bit4 rx_overrun; bit5 tx_overflow. Reading STATUS clears bits 4-5 at the edge. If a flag sets in that same cycle, the set wins.
  - 10: div_low. 11: div_high.
- Register map, writes (all take effect at the clock edge):
  - 00: push databus into the TX FIFO. When the FIFO is full the data is dropped and tx_overflow sets.
  - 01: CTRL. Bit0 rx_irq_en and bit1 tx_irq_en are stored. Bit2 is flush: self-clearing and not stored. It empties both FIFOs and clears bits 4-5. A character already handed to the tx engine completes normally.
  - 10: div_low. 11: div_high. Both take effect on divisor the next cycle.
- RX push: on rx_valid when RX is not full, write rx_data. When RX is full, drop rx_data and set rx_overrun, except when a pop happens in the same cycle: then both operations occur and the count is unchanged.
- Flush has priority over a same-cycle push or pop.
- FIFO pointers wrap modulo depth. Counts are $clog2(DEPTH)+1 bits wide; full when count==DEPTH.
- TX FSM:
  - IDLE: if the TX FIFO is not empty and tx_ready=1, then tx_data <= head, pop the head, pulse tx_start for exactly 1 cycle, and go to WAIT_ACK.
  - WAIT_ACK: when tx_ready=0, go to WAIT_DONE.
  - WAIT_DONE: when tx_ready=1, go to IDLE.
  - The minimum spacing between tx_start pulses is 3 cycles.
  - A CPU push and an FSM pop in the same cycle on a full FIFO both succeed.
- rda = RX count != 0 (registered through the count).
- irq = (rx_irq_en & rda) | (tx_irq_en & tx_empty) | rx_overrun | tx_overflow.
- Write latency: write at edge N makes the status change visible in cycle N+1.
- Read latency: data is valid in the same cycle as the access.

Test Plan:
- Reset, then write 0x45 to 10 and 0x01 to 11 -> divisor=0x0145 one cycle later; reading 10 and 11 returns 0x45 and 0x01; databus is Z whenever iocs=0.
- With tx_ready held 0, push 0x11..0x18 (8 bytes) -> STATUS bit1=0; a 9th push of 0x99 -> tx_overflow=1, irq=1. Reading STATUS clears the flag. Release tx_ready with the model dropping it 1 cycle after tx_start and raising it 10 cycles later -> 8 tx_start pulses with tx_data 0x11..0x18 in order; then tx_empty=1.
- Pulse rx_valid with 0xA0..0xA7 -> rda=1 and rx_full=1. A further rx_valid of 0xFF -> rx_overrun=1. Eight reads of 00 return 0xA0..0xA7, then rda=0; a further read returns 0x00 with count still 0.
- RX full, rx_valid of 0xB5 in the same cycle as a pop -> no overrun; the last read of the sequence returns 0xB5.
- Write CTRL=0x01 with RX empty -> irq=0; one rx_valid -> irq=1 next cycle. Write CTRL=0x04 with both FIFOs partly full -> both counts are 0 next cycle and the CTRL enables are cleared.
- Assert rst low mid-transmission (FSM in WAIT_DONE, FIFOs non-empty) -> all outputs return to reset values immediately and no tx_start occurs after rst is released until new data is pushed.
